// File: rtl/letter_input_encoder.sv
// rtl/letter_input_encoder.sv - PS/2 set-2 byte decoder emitting letter/Enter key events.
// Optional typematic repeat suppression: define REPEAT_FILTER_EN.
module letter_input_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       load,
    output logic [4:0] load_x,
    output logic       key_held
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        EXT       = 2'd2,
        EXT_BREAK = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_load;
    logic [4:0] r_load_x;
    logic [4:0] r_held_idx;
    logic       r_held_vld;

    logic       w_key_vld;
    logic [4:0] w_key_idx;
    logic       w_repeat;
    logic       w_emit;
    logic       w_release;

    always_comb begin
        w_key_vld = 1'b1;
        w_key_idx = 5'd0;
        case (scan_code)
            8'h1C: w_key_idx = 5'd0;
            8'h32: w_key_idx = 5'd1;
            8'h21: w_key_idx = 5'd2;
            8'h23: w_key_idx = 5'd3;
            8'h24: w_key_idx = 5'd4;
            8'h2B: w_key_idx = 5'd5;
            8'h34: w_key_idx = 5'd6;
            8'h33: w_key_idx = 5'd7;
            8'h43: w_key_idx = 5'd8;
            8'h3B: w_key_idx = 5'd9;
            8'h42: w_key_idx = 5'd10;
            8'h4B: w_key_idx = 5'd11;
            8'h3A: w_key_idx = 5'd12;
            8'h31: w_key_idx = 5'd13;
            8'h44: w_key_idx = 5'd14;
            8'h4D: w_key_idx = 5'd15;
            8'h15: w_key_idx = 5'd16;
            8'h2D: w_key_idx = 5'd17;
            8'h1B: w_key_idx = 5'd18;
            8'h2C: w_key_idx = 5'd19;
            8'h3C: w_key_idx = 5'd20;
            8'h2A: w_key_idx = 5'd21;
            8'h1D: w_key_idx = 5'd22;
            8'h22: w_key_idx = 5'd23;
            8'h35: w_key_idx = 5'd24;
            8'h1A: w_key_idx = 5'd25;
            8'h5A: w_key_idx = 5'd26;
            default: w_key_vld = 1'b0;
        endcase
    end

`ifdef REPEAT_FILTER_EN
    assign w_repeat = r_held_vld && (r_held_idx == w_key_idx);
`else
    assign w_repeat = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_release   = 1'b0;
        if (scan_valid) begin
            case (r_state)
                IDLE: begin
                    if (scan_code == 8'hF0)
                        w_state_nxt = BREAK;
                    else if (scan_code == 8'hE0)
                        w_state_nxt = EXT;
                    else
                        w_emit = w_key_vld && !w_repeat;
                end
                BREAK: begin
                    if (scan_code == 8'hF0)
                        w_state_nxt = BREAK;
                    else if (scan_code == 8'hE0)
                        w_state_nxt = EXT;
                    else begin
                        w_state_nxt = IDLE;
                        w_release   = w_key_vld && r_held_vld && (r_held_idx == w_key_idx);
                    end
                end
                EXT: begin
                    w_state_nxt = (scan_code == 8'hF0) ? EXT_BREAK : IDLE;
                end
                EXT_BREAK: begin
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_load     <= 1'b0;
            r_load_x   <= 5'd0;
            r_held_idx <= 5'd0;
            r_held_vld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_load  <= w_emit;
            if (w_emit) begin
                r_load_x   <= w_key_idx;
                r_held_idx <= w_key_idx;
                r_held_vld <= 1'b1;
            end else if (w_release) begin
                r_held_vld <= 1'b0;
            end
        end
    end

    assign load     = r_load;
    assign load_x   = r_load_x;
    assign key_held = r_held_vld;

endmodule

// File: tb/tb_letter_input_encoder.sv
// tb/tb_letter_input_encoder.sv - directed bench with prefix-flag reference model for letter_input_encoder.
module tb_letter_input_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       load;
    logic [4:0] load_x;
    logic       key_held;

    letter_input_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .load       (load),
        .load_x     (load_x),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef REPEAT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    // Letters A..Z in alphabetical order, Enter appended as index 26.
    logic [7:0] key_codes [27] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h5A};

    bit       started = 1'b0;
    bit       pend_brk, pend_ext;
    bit       m_load, m_held;
    int       m_x, m_hidx;

    function automatic int lookup(input logic [7:0] c);
        for (int i = 0; i < 27; i++)
            if (key_codes[i] == c) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        int k;
        if (reset) begin
            started = 1'b1;
            pend_brk = 0; pend_ext = 0;
            m_load = 0; m_x = 0; m_held = 0; m_hidx = 0;
        end else begin
            m_load = 0;
            if (scan_valid) begin
                k = lookup(scan_code);
                if (pend_ext && pend_brk) begin
                    pend_ext = 0; pend_brk = 0;
                end else if (pend_ext) begin
                    if (scan_code == 8'hF0) pend_brk = 1;
                    else pend_ext = 0;
                end else if (scan_code == 8'hF0) begin
                    pend_brk = 1;
                end else if (scan_code == 8'hE0) begin
                    pend_ext = 1; pend_brk = 0;
                end else if (pend_brk) begin
                    if (k >= 0 && m_held && k == m_hidx) m_held = 0;
                    pend_brk = 0;
                end else if (k >= 0 && !(FILTER && m_held && k == m_hidx)) begin
                    m_load = 1; m_x = k; m_held = 1; m_hidx = k;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_load", int'(load), int'(m_load));
            check("model_load_x", int'(load_x), m_x);
            check("model_key_held", int'(key_held), int'(m_held));
        end
    end

    task automatic step(input logic r, input logic v, input logic [7:0] c);
        @(negedge clk);
        reset = r; scan_valid = v; scan_code = c;
        @(posedge clk);
        #1;
    endtask

    int pulses;

    initial begin
        reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00;
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        check("reset_load", int'(load), 0);
        check("reset_load_x", int'(load_x), 0);
        check("reset_key_held", int'(key_held), 0);

        step(0, 1, 8'h1C);
        check("a_load", int'(load), 1);
        check("a_load_x", int'(load_x), 0);
        check("a_held", int'(key_held), 1);
        step(0, 0, 8'h00);
        check("a_single_pulse", int'(load), 0);
        step(0, 1, 8'hF0);
        step(0, 1, 8'h1C);
        check("a_break_noload", int'(load), 0);
        check("a_released", int'(key_held), 0);

        step(0, 1, 8'h5A);
        check("enter_load", int'(load), 1);
        check("enter_x", int'(load_x), 26);
        step(0, 1, 8'hE0);
        step(0, 1, 8'h5A);
        check("kp_enter_noload", int'(load), 0);
        check("kp_enter_x_kept", int'(load_x), 26);
        step(0, 1, 8'h1C);
        check("idle_after_ext", int'(load), 1);

        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h1A);
            if (load) pulses++;
            step(0, 0, 8'h00);
        end
        check("repeat_pulses", pulses, FILTER ? 1 : 3);
        check("repeat_x", int'(load_x), 25);

        step(0, 1, 8'h24);
        check("e_load", int'(load), 1);
        check("e_x", int'(load_x), 4);
        step(0, 1, 8'h32);
        check("b_load", int'(load), 1);
        check("b_x", int'(load_x), 1);
        check("b_held", int'(key_held), 1);
        step(0, 1, 8'hF0);
        step(0, 1, 8'h24);
        check("stale_break_keeps", int'(key_held), 1);
        step(0, 1, 8'hF0);
        step(0, 1, 8'h32);
        check("b_released", int'(key_held), 0);

        step(0, 1, 8'hF0);
        step(1, 1, 8'h1C);
        check("rst_mid_load", int'(load), 0);
        check("rst_mid_x", int'(load_x), 0);
        check("rst_mid_held", int'(key_held), 0);
        step(0, 1, 8'h43);
        check("i_after_rst_load", int'(load), 1);
        check("i_after_rst_x", int'(load_x), 8);

        pulses = 0;
        step(0, 1, 8'h16); if (load) pulses++;
        step(0, 1, 8'h76); if (load) pulses++;
        step(0, 1, 8'hE0); if (load) pulses++;
        step(0, 1, 8'hF0); if (load) pulses++;
        step(0, 1, 8'h75); if (load) pulses++;
        step(0, 0, 8'h00); if (load) pulses++;
        check("unmapped_pulses", pulses, 0);
        check("unmapped_x_kept", int'(load_x), 8);

        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
